// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - FIFO-buffered 8-bit UART transmitter for result bytes; optional even parity via RESULT_UART_TX_PARITY_EN
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count
);

  localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C   = 4'(FIFO_DEPTH);
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef RESULT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic               tx_nxt;
  logic               pop;
  logic               push;
  logic               fifo_nonempty;
  logic               bit_done;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
`ifdef RESULT_UART_TX_PARITY_EN
  logic               parity_bit;
`endif

  // Readiness and busy derive only from registered state, so in_ready never depends on in_valid
  assign in_ready = (fifo_count != DEPTH_C);
  assign busy     = (state != IDLE) || (fifo_count != 4'd0);

  // Next-state, next tx level and pop decision; tx_nxt is the level of the bit that starts on the next edge
  always_comb begin
    push          = in_valid && in_ready;
    fifo_nonempty = (fifo_count != 4'd0);
    bit_done      = (baud_cnt == BAUD_LAST);
    state_nxt     = state;
    tx_nxt        = tx;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          tx_nxt    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = parity_bit;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            tx_nxt = shift_reg[1];
          end
        end
      end
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (fifo_nonempty) begin
            // Back-to-back frames: the next start bit follows the stop bit with no idle gap
            pop       = 1'b1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // State register, registered tx, baud counter and shift register; a pop reloads the bit timing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= 8'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        baud_cnt  <= 8'd0;
        bit_idx   <= 3'd0;
`ifdef RESULT_UART_TX_PARITY_EN
        parity_bit <= ^mem[rd_ptr];
`endif
      end else if (state != IDLE) begin
        if (bit_done) begin
          baud_cnt <= 8'd0;
          if (state == DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 8'd1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 4'd1;
        2'b01:   fifo_count <= fifo_count - 4'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; reset blocks the write so reset wins over a same-cycle push
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - scoreboard testbench for result_uart_tx with a frame-level reference model
`timescale 1ns/1ps
module tb_result_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F  = C * NB;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] in_data  = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;

  result_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] mq[$];
  int         rem       = 0;
  bit         abort_req = 1'b0;
  int         n_checks  = 0;
  int         n_pass    = 0;

  function automatic void check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
  endfunction

  // Line waveform of one frame, one sample per clock: start 0, data LSB first, optional even parity, stop 1
  function automatic logic [63:0] expected_wave(input logic [7:0] b);
    logic [63:0] w;
    logic        bv;
    w = '0;
    for (int i = 0; i < NB; i++) begin
      if (i == 0)                   bv = 1'b0;
      else if (i <= 8)              bv = b[i-1];
      else if (NB == 11 && i == 9)  bv = ^b;
      else                          bv = 1'b1;
      for (int j = 0; j < C; j++) w[i*C+j] = bv;
    end
    return w;
  endfunction

  // One clock: compare DUT against the model, drive inputs, advance the model over the coming edge
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    bit     pop_m;
    bit     push_m;
    frame_t f;
    @(negedge clk);
    check("fifo_count", fifo_count, mq.size());
    check("in_ready", in_ready, mq.size() != D);
    check("busy", busy, (rem > 0) || (mq.size() > 0));
    if (rem == 0) check("tx_idle_high", tx, 1);
    in_valid = v;
    in_data  = d;
    rst      = r;
    if (r) begin
      mq.delete();
      exp_q.delete();
      rem       = 0;
      abort_req = 1'b1;
    end else begin
      pop_m  = (mq.size() > 0) && (rem <= 1);
      push_m = v && (mq.size() < D);
      if (pop_m) begin
        f.data  = mq.pop_front();
        f.start = cyc + 1;
        exp_q.push_back(f);
        rem = F;
      end else if (rem > 0) begin
        rem--;
      end
      if (push_m) mq.push_back(d);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((rem > 0 || mq.size() > 0) && n < max_cycles) begin
      step(1'b0, 8'd0, 1'b0);
      n++;
    end
    if (rem > 0 || mq.size() > 0) check("drain_done", 0, 1);
  endtask

  // Monitor: captures each frame on tx and compares it with the next expected frame
  initial begin : monitor
    bit          in_frame;
    int          idx;
    logic [63:0] wave;
    frame_t      cur;
    in_frame = 1'b0;
    idx      = 0;
    wave     = '0;
    forever begin
      @(posedge clk);
      #2;
      if (abort_req) begin
        abort_req = 1'b0;
        in_frame  = 1'b0;
      end else if (in_frame) begin
        wave[idx] = tx;
        idx++;
        if (idx == F) begin
          check("frame_wave", wave, expected_wave(cur.data));
          in_frame = 1'b0;
        end
      end else if (tx === 1'b0) begin
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("frame_start_cycle", cyc, cur.start);
          wave     = '0;
          wave[0]  = tx;
          idx      = 1;
          in_frame = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    repeat (3) step(1'b0, 8'd0, 1'b1);

    step(1'b1, 8'hA5, 1'b0);
    wait_idle(200);
`ifdef RESULT_UART_TX_PARITY_EN
    step(1'b1, 8'h01, 1'b0);
    wait_idle(200);
`endif

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    wait_idle(400);

    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    wait_idle(600);

    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    repeat (F + 4*C - 2) step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    repeat (2*F) step(1'b0, 8'd0, 1'b0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 299) == 0);
    wait_idle(1000);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("frames_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per UART bit; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, input FIFO entries; legal values 2, 4, 8.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_data, input, 8 bits: result byte from the user design's uo_out.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: FIFO can accept a byte.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is being shifted or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, 4 bits: current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-011 SHALL accept in_data into the FIFO on a rising edge where in_valid and in_ready are both 1.
REQ-012 SHALL drive in_ready = (fifo_count != FIFO_DEPTH), combinationally from registered count only, with no dependence on in_valid.
REQ-013 SHALL, when full, hold in_ready low even in a cycle where a pop occurs; there is no full-bypass path.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-015 SHALL, in IDLE with fifo_count > 0, pop the head entry into the shift register and enter START on the same edge.
REQ-016 SHALL handle a byte accepted at edge N into an empty FIFO in IDLE: pop at edge N+1, tx low from edge N+1.
REQ-017 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles using a baud counter reloaded on each bit boundary.
REQ-018 SHALL send the frame as start bit 0, then data LSB first (8 bits), then optional parity, then stop bit 1.
REQ-019 SHALL, at the end of STOP, pop and enter START directly if the FIFO is non-empty (no idle gap), else enter IDLE.
REQ-020 SHALL apply a push and a pop on the same edge together, leaving fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL ignore in_data while in_valid is 0; in_valid asserted while full is dropped silently, with no state change.
REQ-022 SHALL register tx (glitch-free); busy = (state != IDLE) or (fifo_count != 0).

Reset
REQ-023 SHALL, when rst=1 at a rising edge: state=IDLE, tx=1, fifo_count=0, pointers=0, baud counter=0, in_ready=1 after the edge, busy=0.
REQ-024 SHALL, on reset mid-frame, abort the frame, drive tx high on the next edge, and discard FIFO contents.
REQ-025 SHALL give rst priority over every push and pop in the same cycle.

Configuration
REQ-026 SHALL support macro RESULT_UART_TX_PARITY_EN; when defined, insert a PARITY state after DATA sending the even-parity bit (XOR of the 8 data bits), making the frame 11 bits.
REQ-027 SHALL, with RESULT_UART_TX_PARITY_EN undefined, omit the PARITY state and logic entirely; the frame is 10 bits.

Verification
REQ-028 SHALL pass this scenario (CLKS_PER_BIT=4, no parity): push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total, then busy=0.
REQ-029 SHALL pass this scenario (CLKS_PER_BIT=4, parity enabled): push 0xA5 -> parity bit 0 after data; push 0x01 -> parity bit 1; frames are 44 cycles each.
REQ-030 SHALL pass this scenario: push 5 bytes back-to-back with FIFO_DEPTH=4 -> first popped at once, in_ready never low, all 5 frames contiguous with no idle gap.
REQ-031 SHALL pass this scenario: hold in_valid=1 for 8 cycles while tx busy -> fifo_count saturates at 4, in_ready=0, extra bytes dropped, exactly 5 frames sent.
REQ-032 SHALL pass this scenario: assert rst during data bit 3 of frame 2 with 2 bytes queued -> next edge tx=1, fifo_count=0, busy=0; no further frames.
REQ-033 SHALL pass this scenario: full FIFO with push attempt on the pop edge -> push rejected, fifo_count goes 4->3.
